// File: rtl/write_back.sv
// write_back: final pipeline stage. Retires the instruction from the
// memory-access stage, owns the integer register file (x0 hardwired to zero),
// serves two combinational read ports with same-cycle write bypass, and keeps
// the instret/cycle counters plus an illegal-opcode pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   halt           suppresses retirement this cycle
//   wb_valid       instruction_in/wb_data_in carry a real instruction
//   instruction_in retiring instruction word
//   wb_data_in     result to write into rd
//   rs1_addr/rs2_addr, rs1_data/rs2_data  combinational read ports
//   fwd_rd/fwd_data  rd and value written on the previous edge (rd=0 if none)
//   instret/cycle  retired-instruction and cycle counters (wrap)
//   illegal_instr  one-cycle pulse when an unsupported opcode retires
module write_back #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  instruction_in,
  input  logic [XLEN-1:0]  wb_data_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycle,
  output logic             illegal_instr
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [XLEN-1:0]  r_regs [1:NREG-1];
  logic [4:0]       r_fwd_rd;
  logic [XLEN-1:0]  r_fwd_data;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_cycle;
  logic             r_illegal;

  logic [6:0] w_opc;
  logic [4:0] w_rd;
  logic       w_valid;
  logic       w_writes;
  logic       w_legal;
  logic       w_retire;
  logic       w_we;

  assign w_opc = instruction_in[6:0];
  assign w_rd  = instruction_in[11:7];

  // Only a definite 1 on wb_valid counts; X/Z is treated as a bubble.
  assign w_valid = (wb_valid === 1'b1);

  always_comb begin
    w_writes = 1'b0;
    w_legal  = 1'b0;
    case (w_opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_LOAD, OPC_JAL, OPC_JALR: begin
        w_writes = 1'b1;
        w_legal  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: w_legal = 1'b1;
      default: ;
    endcase
  end

  assign w_retire = rst_n & w_valid & ~halt;
  assign w_we     = w_retire & w_writes & (w_rd != 5'd0) & (32'(w_rd) < NREG);

  // Read ports: x0 and out-of-range addresses read zero; a write landing on
  // this edge is bypassed so decode sees it in the same cycle.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0 && 32'(rs1_addr) < NREG) begin
      if (w_we && w_rd == rs1_addr) rs1_data = wb_data_in;
      else                          rs1_data = r_regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0 && 32'(rs2_addr) < NREG) begin
      if (w_we && w_rd == rs2_addr) rs2_data = wb_data_in;
      else                          rs2_data = r_regs[rs2_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREG; i++) r_regs[i] <= '0;
      r_fwd_rd   <= '0;
      r_fwd_data <= '0;
      r_instret  <= '0;
      r_cycle    <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_we) begin
        r_regs[w_rd] <= wb_data_in;
        r_fwd_data   <= wb_data_in;
      end
      r_fwd_rd <= w_we ? w_rd : 5'd0;
      if (w_retire && w_legal) r_instret <= r_instret + 1'b1;
      r_illegal <= w_retire & ~w_legal;
    end
  end

  assign fwd_rd        = r_fwd_rd;
  assign fwd_data      = r_fwd_data;
  assign instret       = r_instret;
  assign cycle         = r_cycle;
  assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed scenarios followed by random
// traffic, compared against an architectural model of the register file and
// counters. A second instance with 4-bit counters exercises counter wrap.
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst_n, halt, wb_valid;
  logic [31:0] instruction_in, wb_data_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, fwd_data;
  logic [4:0]  fwd_rd;
  logic [63:0] instret, cycle;
  logic        illegal_instr;

  logic [31:0] rs1_data_w, rs2_data_w, fwd_data_w;
  logic [4:0]  fwd_rd_w;
  logic [3:0]  instret_w, cycle_w;
  logic        illegal_instr_w;

  always #5 clk = ~clk;

  write_back #(.XLEN(32), .NREG(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .wb_valid(wb_valid),
    .instruction_in(instruction_in), .wb_data_in(wb_data_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .instret(instret), .cycle(cycle), .illegal_instr(illegal_instr)
  );

  write_back #(.XLEN(32), .NREG(32), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .halt(halt), .wb_valid(wb_valid),
    .instruction_in(instruction_in), .wb_data_in(wb_data_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_w), .rs2_data(rs2_data_w),
    .fwd_rd(fwd_rd_w), .fwd_data(fwd_data_w),
    .instret(instret_w), .cycle(cycle_w), .illegal_instr(illegal_instr_w)
  );

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, LOAD = 7'b0000011, JAL = 7'b1101111,
                         JALR = 7'b1100111, STORE = 7'b0100011, BRANCH = 7'b1100011;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [31:0] m_x [32];
  logic [63:0] m_instret, m_cycle;
  logic [4:0]  m_fwd_rd;
  logic [31:0] m_fwd_data;
  logic        m_ill;

  function automatic bit is_writing(input logic [6:0] o);
    return o == OP || o == OPI || o == LUI || o == AUIPC ||
           o == LOAD || o == JAL || o == JALR;
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return is_writing(o) || o == STORE || o == BRANCH;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] o, input logic [4:0] rd);
    logic [31:0] r;
    r = $urandom;
    r[6:0]  = o;
    r[11:7] = rd;
    return r;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit we,
                                           input logic [4:0] rd, input logic [31:0] d);
    if (a == 5'd0)          return 32'd0;
    if (we && rd == a)      return d;
    return m_x[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check the read ports before the edge, advance the
  // model across the edge, then check registered outputs after it.
  task automatic step(input logic rst, input logic hlt, input logic vld,
                      input logic [31:0] ins, input logic [31:0] dat,
                      input logic [4:0] a1, input logic [4:0] a2, input bit chk_rd);
    logic [6:0] opc;
    logic [4:0] rd;
    bit ret, we;
    rst_n = rst; halt = hlt; wb_valid = vld;
    instruction_in = ins; wb_data_in = dat;
    rs1_addr = a1; rs2_addr = a2;
    #1;
    opc = ins[6:0];
    rd  = ins[11:7];
    ret = (rst === 1'b1) && (vld === 1'b1) && (hlt === 1'b0);
    we  = ret && is_writing(opc) && rd != 5'd0;
    if (chk_rd) begin
      chk("rs1_data", {32'd0, rs1_data}, {32'd0, exp_read(a1, we, rd, dat)});
      chk("rs2_data", {32'd0, rs2_data}, {32'd0, exp_read(a2, we, rd, dat)});
    end
    @(posedge clk);
    if (rst !== 1'b1) begin
      foreach (m_x[i]) m_x[i] = 32'd0;
      m_instret = 0; m_cycle = 0; m_fwd_rd = 0; m_fwd_data = 0; m_ill = 0;
    end else begin
      m_cycle++;
      if (ret && is_legal(opc)) m_instret++;
      m_ill = ret && !is_legal(opc);
      if (we) begin
        m_x[rd] = dat;
        m_fwd_data = dat;
      end
      m_fwd_rd = we ? rd : 5'd0;
    end
    #1;
    chk("instret",   instret,          m_instret);
    chk("cycle",     cycle,            m_cycle);
    chk("fwd_rd",    {59'd0, fwd_rd},  {59'd0, m_fwd_rd});
    chk("fwd_data",  {32'd0, fwd_data}, {32'd0, m_fwd_data});
    chk("illegal",   {63'd0, illegal_instr}, {63'd0, m_ill});
    chk("instret_w", {60'd0, instret_w}, {60'd0, m_instret[3:0]});
    chk("cycle_w",   {60'd0, cycle_w},   {60'd0, m_cycle[3:0]});
  endtask

  logic [6:0] legal_ops [9];

  initial begin
    legal_ops = '{OP, OPI, LUI, AUIPC, LOAD, JAL, JALR, STORE, BRANCH};

    // Reset held two edges with a valid ADD rd=5 presented
    step(1'b0, 1'b0, 1'b1, mk(OP, 5'd5), 32'h1111_1111, 5'd5, 5'd5, 1'b0);
    step(1'b0, 1'b0, 1'b1, mk(OP, 5'd5), 32'h2222_2222, 5'd5, 5'd1, 1'b1);
    // First active edge: x5 must still read 0 before it
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd5, 5'd31, 1'b1);
    chk("x5_after_reset", {32'd0, rs1_data}, 64'd0);

    // Basic write, then read back
    step(1'b1, 1'b0, 1'b1, mk(OP, 5'd3), 32'hDEAD_BEEF, 5'd1, 5'd2, 1'b1);
    chk("basic_fwd_rd", {59'd0, fwd_rd}, 64'd3);
    // LOAD rd=7 with rs2 bypass, rs1 reading stored x3
    step(1'b1, 1'b0, 1'b1, mk(LOAD, 5'd7), 32'h1234_5678, 5'd3, 5'd7, 1'b1);
    chk("bypass_rs2", {32'd0, rs2_data}, 64'h1234_5678);
    // JAL rd=0, STORE with rd field 9
    step(1'b1, 1'b0, 1'b1, mk(JAL, 5'd0), 32'h40, 5'd0, 5'd9, 1'b1);
    step(1'b1, 1'b0, 1'b1, mk(STORE, 5'd9), 32'hFF, 5'd9, 5'd0, 1'b1);
    // Halt with OP_IMM rd=4
    step(1'b1, 1'b1, 1'b1, mk(OPI, 5'd4), 32'h5555_AAAA, 5'd4, 5'd9, 1'b1);
    // Bubble with X payload
    step(1'b1, 1'b0, 1'b0, 'x, 'x, 5'd4, 5'd7, 1'b1);
    // Illegal opcode, then bubble: pulse must drop
    step(1'b1, 1'b0, 1'b1, mk(7'b1111111, 5'd6), 32'hCAFE_F00D, 5'd6, 5'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, mk(OP, 5'd3), 32'h0BAD_0BAD, 5'd6, 5'd3, 1'b1);
    chk("no_bypass_when_idle", {32'd0, rs2_data}, 64'hDEAD_BEEF);

    // Counter wrap on the 4-bit instance: 16 BRANCH retires from reset
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 1'b1, mk(BRANCH, 5'($urandom)), $urandom, 5'($urandom), 5'($urandom), 1'b1);
    chk("wrap_small", {60'd0, instret_w}, 64'd0);
    chk("wrap_full",  instret, 64'd16);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [6:0]  o;
      logic [4:0]  rd, a1, a2;
      logic [31:0] ins;
      if ($urandom_range(9) == 0) begin
        o = 7'($urandom);
        for (int k = 0; k < 16 && is_legal(o); k++) o = 7'($urandom);
        if (is_legal(o)) o = 7'b1111111;
      end else begin
        o = legal_ops[$urandom_range(8)];
      end
      rd  = 5'($urandom);
      ins = mk(o, rd);
      a1  = ($urandom_range(2) == 0) ? rd : 5'($urandom);
      a2  = ($urandom_range(2) == 0) ? rd : 5'($urandom);
      step(($urandom_range(63) != 0), ($urandom_range(7) == 0), ($urandom_range(7) != 0),
           ins, $urandom, a1, a2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
